// File: rtl/shift_rows_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : shift_rows_pipe
//  Description : Pipelined AES/Rijndael ShiftRows stage for Nb = 4, 6 or 8
//                columns. A valid/ready handshake accepts one block per
//                cycle. The row rotation is pure wiring ahead of stage 0,
//                and STAGES plain register slices follow it.
//                Optional feature macro: SHIFTROWS_INV_EN. When it is
//                defined, in_inv selects InvShiftRows per block. When it is
//                undefined, only the forward network exists and out_inv is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [32*NB-1:0] in_block,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_block,
    output logic             out_inv,
    output logic             busy
);
    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1 to 3");
    end

    // Rijndael row offsets. The wide block (Nb=8) uses larger offsets on rows 2 and 3.
    function automatic int row_shift(input int r);
        if (r == 0) return 0;
        if (r == 1) return 1;
        return (NB == 8) ? r + 1 : r;
    endfunction

    // ------------------------------------------------------------------
    // Permutation networks (byte k = r + 4c sits at bits [W-1-8k -: 8])
    // ------------------------------------------------------------------
    wire  [W-1:0] w_fwd_block;
    logic [W-1:0] w_stage0_block;
`ifdef SHIFTROWS_INV_EN
    wire  [W-1:0] w_inv_block;
`endif

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int C_SH  = row_shift(r);
            localparam int C_DST = W - 1 - 8 * (r + 4 * c);
            localparam int C_FWD = W - 1 - 8 * (r + 4 * ((c + C_SH) % NB));
            assign w_fwd_block[C_DST -: 8] = in_block[C_FWD -: 8];
`ifdef SHIFTROWS_INV_EN
            // The inverse gathers from the column that the forward pass scattered to.
            localparam int C_INV = W - 1 - 8 * (r + 4 * ((c + NB - C_SH) % NB));
            assign w_inv_block[C_DST -: 8] = in_block[C_INV -: 8];
`endif
        end
    end

`ifdef SHIFTROWS_INV_EN
    assign w_stage0_block = in_inv ? w_inv_block : w_fwd_block;
`else
    // Direction select is absent in this build; in_inv is intentionally unused.
    logic w_unused_inv;
    assign w_unused_inv   = in_inv;
    assign w_stage0_block = w_fwd_block;
`endif

    // ------------------------------------------------------------------
    // Register pipeline
    // ------------------------------------------------------------------
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] w_adv;
    logic [W-1:0]      data_q [STAGES];
    logic [W-1:0]      data_d [STAGES];
`ifdef SHIFTROWS_INV_EN
    logic [STAGES-1:0] inv_q;
    logic [STAGES-1:0] inv_d;
`endif
    logic              w_accept;

    // A stage advances if it or any stage downstream is empty, or the sink takes data.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            w_adv[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!valid_q[j]) w_adv[i] = 1'b1;
            end
        end
    end

    assign in_ready = rst || w_adv[0];
    assign w_accept = in_valid && in_ready;

    // Next-state contents offered to each stage by its upstream neighbour.
    always_comb begin
        valid_d[0] = w_accept;
        data_d[0]  = w_stage0_block;
`ifdef SHIFTROWS_INV_EN
        inv_d[0]   = in_inv;
`endif
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
`ifdef SHIFTROWS_INV_EN
            inv_d[i]   = inv_q[i-1];
`endif
        end
    end

    // Advancing stages take the upstream contents; stalled stages hold their contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
`ifdef SHIFTROWS_INV_EN
                inv_q[i]   <= 1'b0;
`endif
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_adv[i]) begin
                    valid_q[i] <= valid_d[i];
                    if (valid_d[i]) begin
                        data_q[i] <= data_d[i];
`ifdef SHIFTROWS_INV_EN
                        inv_q[i]  <= inv_d[i];
`endif
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_block = data_q[STAGES-1];
    assign busy      = |valid_q;
`ifdef SHIFTROWS_INV_EN
    assign out_inv   = inv_q[STAGES-1];
`else
    assign out_inv   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_rows_pipe
//  Description : Self-checking bench for shift_rows_pipe. Three instances:
//                A (NB=4, STAGES=2), B (NB=8, STAGES=3), C (NB=6, STAGES=1).
//                A queue-based scoreboard follows every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rows_pipe;
`ifdef SHIFTROWS_INV_EN
    localparam logic INV_EN = 1'b1;
`else
    localparam logic INV_EN = 1'b0;
`endif

    typedef struct packed {
        logic [255:0] blk;
        logic         inv;
    } exp_t;

    typedef struct {
        logic [127:0] blk;
        logic         inv;
        logic [127:0] exp_blk;
        logic         exp_inv;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid, in_inv, out_ready;
    logic [255:0] in_blk [3];
    wire  [2:0]   in_ready, out_valid, out_inv, busy;
    wire  [127:0] ob_a;
    wire  [255:0] ob_b;
    wire  [191:0] ob_c;
    logic [255:0] ob [3];

    int tests = 0;
    int fails = 0;
    int pops [3] = '{0, 0, 0};
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    always_comb begin
        ob[0] = {128'b0, ob_a};
        ob[1] = ob_b;
        ob[2] = {64'b0, ob_c};
    end

    shift_rows_pipe #(.NB(4), .STAGES(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_inv(in_inv[0]), .in_block(in_blk[0][127:0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_block(ob_a), .out_inv(out_inv[0]), .busy(busy[0]));

    shift_rows_pipe #(.NB(8), .STAGES(3)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_inv(in_inv[1]), .in_block(in_blk[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_block(ob_b), .out_inv(out_inv[1]), .busy(busy[1]));

    shift_rows_pipe #(.NB(6), .STAGES(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_inv(in_inv[2]), .in_block(in_blk[2][191:0]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_block(ob_c), .out_inv(out_inv[2]), .busy(busy[2]));

    function automatic int nb_of(input int x);
        return (x == 0) ? 4 : (x == 1) ? 8 : 6;
    endfunction

    function automatic int tgt_of(input int x);
        return (x == 0) ? 96 : 48;
    endfunction

    // Reference ShiftRows written straight from the state definition (inverse as a scatter).
    function automatic logic [255:0] ref_perm(input logic [255:0] blk, input int nb, input logic inv);
        logic [255:0] r = '0;
        int w = 32 * nb;
        int sh;
        for (int c = 0; c < nb; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                sh = (rr == 0) ? 0 : (rr == 1) ? 1 : (nb == 8) ? rr + 1 : rr;
                if (!inv) r[w-1-8*(rr+4*c) -: 8] = blk[w-1-8*(rr+4*((c+sh)%nb)) -: 8];
                else      r[w-1-8*(rr+4*((c+sh)%nb)) -: 8] = blk[w-1-8*(rr+4*c) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [255:0] rand_blk(input int nb);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        if (nb < 8) r = r & ((256'd1 << (32 * nb)) - 256'd1);
        return r;
    endfunction

    function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic int q_size(input int x);
        return (x == 0) ? q0.size() : (x == 1) ? q1.size() : q2.size();
    endfunction

    function automatic void q_push(input int x, input exp_t e);
        if (x == 0) q0.push_back(e); else if (x == 1) q1.push_back(e); else q2.push_back(e);
    endfunction

    function automatic exp_t q_pop(input int x);
        if (x == 0) return q0.pop_front();
        if (x == 1) return q1.pop_front();
        return q2.pop_front();
    endfunction

    // Scoreboard: push the model result on each accepted input, compare on each output beat.
    always @(negedge clk) begin
        exp_t e;
        for (int x = 0; x < 3; x++) begin
            if (rst) begin
                if (x == 0) q0.delete(); else if (x == 1) q1.delete(); else q2.delete();
            end else begin
                if (out_valid[x] && out_ready[x]) begin
                    pops[x]++;
                    if (q_size(x) == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb%0d_unexpected: got %h expected no output", x, ob[x]);
                    end else begin
                        e = q_pop(x);
                        check($sformatf("sb%0d_blk", x), ob[x], e.blk);
                        check($sformatf("sb%0d_inv", x), {255'b0, out_inv[x]}, {255'b0, e.inv});
                    end
                end
                if (in_valid[x] && in_ready[x]) begin
                    e.inv = in_inv[x] & INV_EN;
                    e.blk = ref_perm(in_blk[x], nb_of(x), e.inv);
                    q_push(x, e);
                end
            end
        end
    end

    // Send one block into an idle instance and wait (bounded) for its output.
    task automatic send_wait(input int x, input logic [255:0] blk, input logic inv,
                             output logic [255:0] res, output logic res_inv, output int cyc);
        @(posedge clk); #1;
        in_valid[x] = 1'b1;
        in_blk[x]   = blk;
        in_inv[x]   = inv;
        @(posedge clk); #1;
        in_valid[x] = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!out_valid[x] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        res     = ob[x];
        res_inv = out_inv[x];
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tv [3];
        logic [255:0] tmp, res, orig, hold;
        logic [255:0] bp [3];
        logic [2:0]   bpinv;
        logic         rinv;
        logic [2:0]   acc_s;
        int           cyc, acc, k, p0, done;
        int           sent [3];
        int           p_s [3];

        tv[0] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                  128'h00050a0f04090e03080d02070c01060b, 1'b0};
        tv[1] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
                  128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0};
`ifdef SHIFTROWS_INV_EN
        tv[2] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1,
                  128'hd42711aee0bf98f1b8b45de51e415230, 1'b1};
`else
        tmp   = ref_perm({128'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5}, 4, 1'b0);
        tv[2] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, tmp[127:0], 1'b0};
`endif

        rst       = 1'b1;
        in_valid  = '0;
        in_inv    = '0;
        out_ready = 3'b111;
        for (int x = 0; x < 3; x++) in_blk[x] = '0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready_during", {253'b0, in_ready}, 256'd7);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {253'b0, out_valid}, 256'd0);
        check("rst_busy", {253'b0, busy}, 256'd0);
        check("rst_out_inv", {253'b0, out_inv}, 256'd0);
        check("rst_in_ready", {253'b0, in_ready}, 256'd7);
        check("rst_out_block_a", ob[0], 256'd0);
        check("rst_out_block_b", ob[1], 256'd0);

        // Table-driven vectors on NB=4, STAGES=2
        for (int i = 0; i < 3; i++) begin
            send_wait(0, {128'b0, tv[i].blk}, tv[i].inv, res, rinv, cyc);
            check($sformatf("vec%0d_latency", i), cyc, 2);
            check($sformatf("vec%0d_blk", i), res, {128'b0, tv[i].exp_blk});
            check($sformatf("vec%0d_inv", i), {255'b0, rinv}, {255'b0, tv[i].exp_inv});
        end

        // NB=8: bytes 00..1f forward, then inverse of the result
        for (int b = 0; b < 32; b++) orig[255-8*b -: 8] = 8'(b);
        send_wait(1, orig, 1'b0, res, rinv, cyc);
        check("nb8_latency", cyc, 3);
        check("nb8_word0", {224'b0, res[255:224]}, {224'b0, 32'h00050e13});
        check("nb8_fwd", res, ref_perm(orig, 8, 1'b0));
        tmp = res;
        send_wait(1, tmp, 1'b1, res, rinv, cyc);
        if (INV_EN) begin
            check("nb8_inv_restore", res, orig);
            check("nb8_inv_flag", {255'b0, rinv}, 256'd1);
        end else begin
            check("nb8_inv_ignored", res, ref_perm(tmp, 8, 1'b0));
            check("nb8_inv_flag", {255'b0, rinv}, 256'd0);
        end

        // NB=6, STAGES=1
        orig = rand_blk(6);
        send_wait(2, orig, 1'b0, res, rinv, cyc);
        check("nb6_latency", cyc, 1);
        check("nb6_fwd", res, ref_perm(orig, 6, 1'b0));

        // Backpressure on STAGES=2: only two blocks fit while out_ready is low
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        for (int j = 0; j < 3; j++) bp[j] = rand_blk(4);
        bpinv = 3'($urandom_range(7));
        in_valid[0] = 1'b1;
        in_blk[0]   = bp[0];
        in_inv[0]   = bpinv[0];
        k = 0;
        acc = 0;
        repeat (3) begin
            @(negedge clk);
            if (in_ready[0]) acc++;
            @(posedge clk); #1;
            if (acc > k) begin
                k = acc;
                if (k < 3) begin
                    in_blk[0] = bp[k];
                    in_inv[0] = bpinv[k];
                end
            end
        end
        @(negedge clk);
        check("bp_accepted", acc, 2);
        check("bp_in_ready_low", {255'b0, in_ready[0]}, 256'd0);
        check("bp_busy", {255'b0, busy[0]}, 256'd1);
        check("bp_head", ob[0], ref_perm(bp[0], 4, bpinv[0] & INV_EN));
        hold = ob[0];
        repeat (3) begin
            @(negedge clk);
            check("bp_stall_stable", ob[0], hold);
        end
        p0 = pops[0];
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_simul_ready", {255'b0, in_ready[0]}, 256'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_outputs", pops[0] - p0, 3);
        check("bp_drained", q_size(0), 0);

        // Reset with two blocks in flight and a handshake offered during reset
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        repeat (2) begin
            in_valid[0] = 1'b1;
            in_blk[0]   = rand_blk(4);
            in_inv[0]   = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("rstop_busy_before", {255'b0, busy[0]}, 256'd1);
        p0 = pops[0];
        @(posedge clk); #1;
        rst          = 1'b1;
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_blk[0]    = rand_blk(4);
        @(negedge clk);
        check("rstop_in_ready_in_rst", {255'b0, in_ready[0]}, 256'd1);
        @(posedge clk); #1;
        rst         = 1'b0;
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("rstop_out_valid", {255'b0, out_valid[0]}, 256'd0);
        check("rstop_busy", {255'b0, busy[0]}, 256'd0);
        check("rstop_out_block", ob[0], 256'd0);
        repeat (5) @(negedge clk);
        check("rstop_no_stale", pops[0] - p0, 0);

        // Streaming: random blocks, random inv and random out_ready on all instances
        for (int x = 0; x < 3; x++) begin
            sent[x] = 0;
            p_s[x]  = pops[x];
        end
        @(posedge clk); #1;
        in_valid = '0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            acc_s = in_valid & in_ready;
            @(posedge clk); #1;
            done = 1;
            for (int x = 0; x < 3; x++) begin
                if (acc_s[x]) sent[x]++;
                if (!in_valid[x] || acc_s[x]) begin
                    if (sent[x] < tgt_of(x) && $urandom_range(3) != 0) begin
                        in_valid[x] = 1'b1;
                        in_blk[x]   = rand_blk(nb_of(x));
                        in_inv[x]   = 1'($urandom_range(1));
                    end else begin
                        in_valid[x] = 1'b0;
                    end
                end
                out_ready[x] = ($urandom_range(2) != 0);
                if (sent[x] < tgt_of(x)) done = 0;
            end
            if (done != 0) break;
        end
        in_valid  = '0;
        out_ready = 3'b111;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (q_size(0) == 0 && q_size(1) == 0 && q_size(2) == 0 && busy == 3'b000) break;
        end
        for (int x = 0; x < 3; x++) begin
            check($sformatf("stream%0d_sent", x), sent[x], tgt_of(x));
            check($sformatf("stream%0d_outputs", x), pops[x] - p_s[x], tgt_of(x));
            check($sformatf("stream%0d_drained", x), q_size(x), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
